// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared opcodes, funct3 codes, control enums and immediate/ALU decode helpers for rv32i_core.
package rv32i_pkg;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;
    localparam logic [2:0] F3_LB   = 3'd0;
    localparam logic [2:0] F3_LH   = 3'd1;
    localparam logic [2:0] F3_LW   = 3'd2;
    localparam logic [2:0] F3_LBU  = 3'd4;
    localparam logic [2:0] F3_LHU  = 3'd5;
    localparam logic [2:0] F3_SB   = 3'd0;
    localparam logic [2:0] F3_SH   = 3'd1;
    localparam logic [2:0] F3_SW   = 3'd2;

    localparam logic [31:0] LED_MMIO_ADDR = 32'hFFFF_FFF0;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic {OP1_RS1, OP1_PC} op1_sel_e;
    typedef enum logic {OP2_RS2, OP2_IMM} op2_sel_e;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    function automatic logic [31:0] gen_imm(imm_fmt_e fmt, logic [31:0] ins);
        case (fmt)
            IMM_S:   return {{21{ins[31]}}, ins[30:25], ins[11:7]};
            IMM_B:   return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   return {ins[31:12], 12'b0};
            IMM_J:   return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            default: return {{21{ins[31]}}, ins[30:20]};
        endcase
    endfunction

    // OP-IMM never subtracts; instruction bit 30 selects SUB/SRA
    function automatic alu_op_e alu_decode(logic [2:0] f3, logic f7b5, logic is_op);
        case (f3)
            3'd0:    return (is_op && f7b5) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return f7b5 ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/rv32i_alu.sv
// rv32i_alu: combinational RV32I ALU; shift amount is i_b[4:0].
module rv32i_alu
    import rv32i_pkg::*;
(
    input  alu_op_e     i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_y
);
    always_comb begin
        case (i_op)
            ALU_SUB:  o_y = i_a - i_b;
            ALU_SLL:  o_y = i_a << i_b[4:0];
            ALU_SLT:  o_y = {31'b0, $signed(i_a) < $signed(i_b)};
            ALU_SLTU: o_y = {31'b0, i_a < i_b};
            ALU_XOR:  o_y = i_a ^ i_b;
            ALU_SRL:  o_y = i_a >> i_b[4:0];
            ALU_SRA:  o_y = $signed(i_a) >>> i_b[4:0];
            ALU_OR:   o_y = i_a | i_b;
            ALU_AND:  o_y = i_a & i_b;
            default:  o_y = i_a + i_b;
        endcase
    end
endmodule

// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I core with instruction/data memory, driving six board LEDs.
// Define LEDS_MMIO_EN to map the LED register at LED_MMIO_ADDR for stores and loads.
module rv32i_core
    import rv32i_pkg::*;
#(
    parameter int          IMEM_WORDS = 1024,
    parameter int          DMEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [5:0] leds
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] program_counter, instruction, Immediate_imm;
    logic [31:0] RF_rdata1, RF_rdata2, RF_wdata, ALU_A, ALU_B, ALU_OUT, DM_OUT;
    logic [4:0]  RF_rsel1, RF_rsel2, RF_wsel;
    logic        branch_taken, DM_wen;
    op1_sel_e    ALU_OP1_SEL;
    op2_sel_e    ALU_OP2_SEL;
    wb_sel_e     RF_wdata_sel;
    alu_op_e     w_alu_op;
    imm_fmt_e    w_imm_fmt;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_is_branch, w_is_jal, w_is_jalr, w_is_load, w_is_store, w_mmio, w_cond;
    logic [31:0] w_pc_plus4, w_pc_next, w_ld_word, w_st_data;
    logic [3:0]  w_be;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    if (1) begin : im
        logic [31:0] mem_array [0:IMEM_WORDS-1];
        logic [31:0] data_out;
        assign data_out = mem_array[program_counter[IAW+1:2]];
    end
    assign instruction = im.data_out;

    if (1) begin : cu
        logic RF_wen;
        assign w_opcode    = instruction[6:0];
        assign w_funct3    = instruction[14:12];
        assign w_is_branch = w_opcode == OP_BRANCH;
        assign w_is_jal    = w_opcode == OP_JAL;
        assign w_is_jalr   = w_opcode == OP_JALR;
        assign w_is_load   = w_opcode == OP_LOAD;
        assign w_is_store  = w_opcode == OP_STORE;
        assign RF_wen      = w_opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP};
        assign w_imm_fmt   = w_is_store ? IMM_S : w_is_branch ? IMM_B : w_is_jal ? IMM_J :
                             (w_opcode == OP_LUI || w_opcode == OP_AUIPC) ? IMM_U : IMM_I;
        assign ALU_OP1_SEL = (w_is_branch || w_is_jal || w_opcode == OP_AUIPC) ? OP1_PC : OP1_RS1;
        assign ALU_OP2_SEL = (w_opcode == OP_OP) ? OP2_RS2 : OP2_IMM;
        assign RF_wdata_sel = w_is_load ? WB_MEM : (w_is_jal || w_is_jalr) ? WB_PC4 : WB_ALU;
        assign w_alu_op    = (w_opcode == OP_OP || w_opcode == OP_IMM) ?
                             alu_decode(w_funct3, instruction[30], w_opcode == OP_OP) : ALU_ADD;
        assign DM_wen      = w_is_store && !w_mmio;
    end

    assign Immediate_imm = gen_imm(w_imm_fmt, instruction);
    // LUI adds its immediate to x0, so its rs1 field is forced to zero
    assign RF_rsel1 = (w_opcode == OP_LUI) ? 5'd0 : instruction[19:15];
    assign RF_rsel2 = instruction[24:20];
    assign RF_wsel  = instruction[11:7];

    if (1) begin : rf
        logic [31:0] registers [0:31];
        always_ff @(posedge clk)
            if (rst)
                for (int i = 0; i < 32; i++) registers[i] <= '0;
            else if (cu.RF_wen && |RF_wsel)
                registers[RF_wsel] <= RF_wdata;
    end
    assign RF_rdata1 = |RF_rsel1 ? rf.registers[RF_rsel1] : '0;
    assign RF_rdata2 = |RF_rsel2 ? rf.registers[RF_rsel2] : '0;

    assign ALU_A = (ALU_OP1_SEL == OP1_PC) ? program_counter : RF_rdata1;
    assign ALU_B = (ALU_OP2_SEL == OP2_IMM) ? Immediate_imm : RF_rdata2;

    rv32i_alu u_alu (.i_op(w_alu_op), .i_a(ALU_A), .i_b(ALU_B), .o_y(ALU_OUT));

    // funct3 values 2 and 3 are not branches and never take
    assign w_cond = (w_funct3[2:1] == 2'b00) ? RF_rdata1 == RF_rdata2 :
                    (w_funct3[2:1] == 2'b10) ? $signed(RF_rdata1) < $signed(RF_rdata2) :
                    RF_rdata1 < RF_rdata2;
    assign branch_taken = w_is_jal || w_is_jalr ||
                          (w_is_branch && w_funct3[2:1] != 2'b01 && (w_cond ^ w_funct3[0]));
    assign w_pc_plus4 = program_counter + 32'd4;
    assign w_pc_next  = w_is_jalr ? {ALU_OUT[31:1], 1'b0} : branch_taken ? ALU_OUT : w_pc_plus4;

    always_ff @(posedge clk)
        if (rst) program_counter <= RESET_PC;
        else program_counter <= w_pc_next;

    assign w_be      = (w_funct3 == F3_SB) ? 4'b0001 << ALU_OUT[1:0] :
                       (w_funct3 == F3_SH) ? (ALU_OUT[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_st_data = (w_funct3 == F3_SB) ? {4{RF_rdata2[7:0]}} :
                       (w_funct3 == F3_SH) ? {2{RF_rdata2[15:0]}} : RF_rdata2;

    if (1) begin : dm
        logic [31:0] mem [0:DMEM_WORDS-1];
        always_ff @(posedge clk)
            if (!rst && DM_wen)
                for (int b = 0; b < 4; b++)
                    if (w_be[b]) mem[ALU_OUT[DAW+1:2]][8*b +: 8] <= w_st_data[8*b +: 8];
    end

    assign w_ld_word = w_mmio ? {26'b0, leds} : dm.mem[ALU_OUT[DAW+1:2]];
    assign w_ld_byte = w_ld_word[8*ALU_OUT[1:0] +: 8];
    assign w_ld_half = ALU_OUT[1] ? w_ld_word[31:16] : w_ld_word[15:0];
    assign DM_OUT    = (w_funct3 == F3_LB)  ? {{24{w_ld_byte[7]}}, w_ld_byte} :
                       (w_funct3 == F3_LH)  ? {{16{w_ld_half[15]}}, w_ld_half} :
                       (w_funct3 == F3_LBU) ? {24'b0, w_ld_byte} :
                       (w_funct3 == F3_LHU) ? {16'b0, w_ld_half} : w_ld_word;

    assign RF_wdata = (RF_wdata_sel == WB_MEM) ? DM_OUT :
                      (RF_wdata_sel == WB_PC4) ? w_pc_plus4 : ALU_OUT;

`ifdef LEDS_MMIO_EN
    logic [5:0] r_leds;
    assign w_mmio = ALU_OUT == LED_MMIO_ADDR;
    always_ff @(posedge clk)
        if (rst) r_leds <= '0;
        else if (w_is_store && w_mmio) r_leds <= RF_rdata2[5:0];
    assign leds = r_leds;
`else
    assign w_mmio = 1'b0;
    assign leds   = '0;
`endif
endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: runs a short hand-assembled program through rv32i_core, checking PC, branch_taken and register results.
module tb_rv32i_core;
    import rv32i_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] leds;
    int         n_chk = 0;
    int         n_fail = 0;

    rv32i_core dut (.clk(clk), .rst(rst), .leds(leds));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        exp_bt;
        logic [31:0] exp_pc;
        logic [4:0]  rd;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(int imm20, int rd, int op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction

    task automatic add(int addr, logic [31:0] instr, int bt, int pc, int rd, int val);
        vec_t v;
        v.addr = addr; v.instr = instr; v.exp_bt = bt[0];
        v.exp_pc = pc; v.rd = rd[4:0]; v.exp_rd = val;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t        e;
        logic [31:0] acc;
        add('h00, enc_i(5, 0, 0, 1, OP_IMM),       0, 'h04, 1,  'h5);
        add('h04, enc_i(-7, 1, 0, 2, OP_IMM),      0, 'h08, 2,  'hFFFFFFFE);
        add('h08, enc_i(-128, 0, 0, 2, OP_IMM),    0, 'h0C, 2,  'hFFFFFF80);
        add('h0C, enc_s(0, 2, 0, 2),               0, 'h10, 2,  'hFFFFFF80);
        add('h10, enc_i(0, 0, 0, 3, OP_LOAD),      0, 'h14, 3,  'hFFFFFF80);
        add('h14, enc_i(1, 0, 4, 4, OP_LOAD),      0, 'h18, 4,  'h000000FF);
        add('h18, enc_b(8, 0, 1, 1),               1, 'h20, 1,  'h5);
        add('h20, enc_j(16, 1),                    1, 'h30, 1,  'h24);
        add('h30, enc_i('h41, 0, 0, 6, OP_IMM),    0, 'h34, 6,  'h41);
        add('h34, enc_i(0, 6, 0, 7, OP_JALR),      1, 'h40, 7,  'h38);
        add('h40, enc_u('h12345, 8, OP_LUI),       0, 'h44, 8,  'h12345000);
        add('h44, enc_u(1, 9, OP_AUIPC),           0, 'h48, 9,  'h1044);
        add('h48, enc_r('h20, 1, 8, 0, 10),        0, 'h4C, 10, 'h12344FDC);
        add('h4C, enc_r('h20, 1, 2, 5, 11),        0, 'h50, 11, 'hFFFFFFF8);
        add('h50, enc_r(0, 2, 1, 3, 12),           0, 'h54, 12, 'h1);
        add('h54, enc_r(0, 1, 2, 2, 13),           0, 'h58, 13, 'h1);
        add('h58, enc_s(2, 1, 0, 1),               0, 'h5C, 1,  'h24);
        add('h5C, enc_i(0, 0, 2, 14, OP_LOAD),     0, 'h60, 14, 'h0024FF80);
        add('h60, enc_i(0, 0, 1, 15, OP_LOAD),     0, 'h64, 15, 'hFFFFFF80);
        add('h64, enc_b(8, 0, 1, 0),               0, 'h68, 1,  'h24);
        add('h68, enc_b(8, 1, 2, 5),               0, 'h6C, 2,  'hFFFFFF80);
        add('h6C, enc_b(12, 2, 1, 6),              1, 'h78, 1,  'h24);
        add('h78, enc_i(7, 1, 0, 0, OP_IMM),       0, 'h7C, 0,  'h0);
        add('h7C, 32'h0000_0073,                   0, 'h80, 1,  'h24);
        add('h80, enc_i('h2A, 0, 0, 5, OP_IMM),    0, 'h84, 5,  'h2A);
        add('h84, enc_s(-16, 5, 0, 2),             0, 'h88, 5,  'h2A);
        add('h88, enc_i(-16, 0, 2, 16, OP_LOAD),   0, 'h8C, 16, 'h2A);
        add('h8C, enc_i(1, 5, 0, 5, OP_IMM),       0, 'h90, 5,  'h2B);

        for (int i = 0; i < 1024; i++) dut.im.mem_array[i] = 32'h0000_0013;
        foreach (vecs[i]) dut.im.mem_array[vecs[i].addr[11:2]] = vecs[i].instr;

        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", dut.program_counter, 32'h0);
        acc = '0;
        for (int i = 1; i < 32; i++) acc |= dut.rf.registers[i];
        check("reset_regs", acc, 32'h0);
        check("reset_leds", {26'b0, leds}, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        foreach (vecs[i]) begin
            check($sformatf("bt_%0d", i), {31'b0, dut.branch_taken}, {31'b0, vecs[i].exp_bt});
            sb.push_back('{pc: vecs[i].exp_pc, rd: vecs[i].rd, val: vecs[i].exp_rd});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("pc_%0d", i), dut.program_counter, e.pc);
            check($sformatf("x%0d_%0d", e.rd, i), dut.rf.registers[e.rd], e.val);
            @(negedge clk);
        end

`ifdef LEDS_MMIO_EN
        check("leds_mmio", {26'b0, leds}, 32'h2A);
`else
        check("leds_off", {26'b0, leds}, 32'h0);
        check("mmio_store_dm", dut.dm.mem[10'h3FC], 32'h2A);
`endif
        check("dm_word0", dut.dm.mem[0], 32'h0024FF80);

        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_pc", dut.program_counter, 32'h0);
        check("midrst_x5", dut.rf.registers[5], 32'h0);
        check("midrst_leds", {26'b0, leds}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rerun_pc", dut.program_counter, 32'h4);
        check("rerun_x1", dut.rf.registers[1], 32'h5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
